// File: rtl/inst_encoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : inst_encoder_pkg                                          |
// | Brief  : MIPS kind enumeration, opcode/func codes, field widths    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package inst_encoder_pkg;

    localparam int c_OP_W   = 6;
    localparam int c_REG_W  = 5;
    localparam int c_FUNC_W = 6;
    localparam int c_IMM_W  = 16;
    localparam int c_TGT_W  = 26;
    localparam int c_KIND_W = 5;

    typedef enum logic [c_KIND_W-1:0] {
        K_ADD  = 5'd0,  K_ADDU = 5'd1,  K_SUB  = 5'd2,  K_SUBU = 5'd3,
        K_SLT  = 5'd4,  K_SLL  = 5'd5,  K_SRL  = 5'd6,  K_SRA  = 5'd7,
        K_JR   = 5'd8,  K_LW   = 5'd9,  K_SW   = 5'd10, K_ORI  = 5'd11,
        K_LUI  = 5'd12, K_ADDI = 5'd13, K_SLTI = 5'd14, K_BEQ  = 5'd15,
        K_BNE  = 5'd16, K_J    = 5'd17, K_JAL  = 5'd18
    } kind_e;

    localparam logic [c_OP_W-1:0] c_OP_RTYPE = 6'b000000;
    localparam logic [c_OP_W-1:0] c_OP_LW    = 6'b100011;
    localparam logic [c_OP_W-1:0] c_OP_SW    = 6'b101011;
    localparam logic [c_OP_W-1:0] c_OP_ORI   = 6'b001101;
    localparam logic [c_OP_W-1:0] c_OP_LUI   = 6'b001111;
    localparam logic [c_OP_W-1:0] c_OP_ADDI  = 6'b001000;
    localparam logic [c_OP_W-1:0] c_OP_SLTI  = 6'b001010;
    localparam logic [c_OP_W-1:0] c_OP_BEQ   = 6'b000100;
    localparam logic [c_OP_W-1:0] c_OP_BNE   = 6'b000101;
    localparam logic [c_OP_W-1:0] c_OP_J     = 6'b000010;
    localparam logic [c_OP_W-1:0] c_OP_JAL   = 6'b000011;

    localparam logic [c_FUNC_W-1:0] c_FN_ADD  = 6'b100000;
    localparam logic [c_FUNC_W-1:0] c_FN_ADDU = 6'b100001;
    localparam logic [c_FUNC_W-1:0] c_FN_SUB  = 6'b100010;
    localparam logic [c_FUNC_W-1:0] c_FN_SUBU = 6'b100011;
    localparam logic [c_FUNC_W-1:0] c_FN_SLT  = 6'b101010;
    localparam logic [c_FUNC_W-1:0] c_FN_SLL  = 6'b000000;
    localparam logic [c_FUNC_W-1:0] c_FN_SRL  = 6'b000010;
    localparam logic [c_FUNC_W-1:0] c_FN_SRA  = 6'b000011;
    localparam logic [c_FUNC_W-1:0] c_FN_JR   = 6'b001000;

    function automatic logic [31:0] f_r_word(
        input logic [c_REG_W-1:0]  rs,
        input logic [c_REG_W-1:0]  rt,
        input logic [c_REG_W-1:0]  rd,
        input logic [c_REG_W-1:0]  shamt,
        input logic [c_FUNC_W-1:0] func
    );
        return {c_OP_RTYPE, rs, rt, rd, shamt, func};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_pack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : inst_pack                                                 |
// | Brief  : combinational map of (kind, fields) to MIPS word + legal  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [c_KIND_W-1:0] kind,
    input  logic [c_REG_W-1:0]  rs,
    input  logic [c_REG_W-1:0]  rt,
    input  logic [c_REG_W-1:0]  rd,
    input  logic [c_REG_W-1:0]  shamt,
    input  logic [c_IMM_W-1:0]  imm,
    input  logic [c_TGT_W-1:0]  target,
    output logic [31:0]         word,
    output logic                legal
);

    localparam logic [c_REG_W-1:0] c_ZR = '0;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind)
            K_ADD:  word = f_r_word(rs, rt, rd, c_ZR, c_FN_ADD);
            K_ADDU: word = f_r_word(rs, rt, rd, c_ZR, c_FN_ADDU);
            K_SUB:  word = f_r_word(rs, rt, rd, c_ZR, c_FN_SUB);
            K_SUBU: word = f_r_word(rs, rt, rd, c_ZR, c_FN_SUBU);
            K_SLT:  word = f_r_word(rs, rt, rd, c_ZR, c_FN_SLT);
            K_SLL:  word = f_r_word(c_ZR, rt, rd, shamt, c_FN_SLL);
            K_SRL:  word = f_r_word(c_ZR, rt, rd, shamt, c_FN_SRL);
            K_SRA:  word = f_r_word(c_ZR, rt, rd, shamt, c_FN_SRA);
            K_JR:   word = f_r_word(rs, c_ZR, c_ZR, c_ZR, c_FN_JR);
            K_LW:   word = {c_OP_LW,   rs,   rt, imm};
            K_SW:   word = {c_OP_SW,   rs,   rt, imm};
            K_ORI:  word = {c_OP_ORI,  rs,   rt, imm};
            K_LUI:  word = {c_OP_LUI,  c_ZR, rt, imm};
            K_ADDI: word = {c_OP_ADDI, rs,   rt, imm};
            K_SLTI: word = {c_OP_SLTI, rs,   rt, imm};
            K_BEQ:  word = {c_OP_BEQ,  rs,   rt, imm};
            K_BNE:  word = {c_OP_BNE,  rs,   rt, imm};
            K_J:    word = {c_OP_J,   target};
            K_JAL:  word = {c_OP_JAL, target};
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : inst_encoder                                              |
// | Brief  : streams instruction beats into encoded IMEM writes        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [c_KIND_W-1:0] in_kind,
    input  logic [c_REG_W-1:0]  in_rs,
    input  logic [c_REG_W-1:0]  in_rt,
    input  logic [c_REG_W-1:0]  in_rd,
    input  logic [c_REG_W-1:0]  in_shamt,
    input  logic [c_IMM_W-1:0]  in_imm,
    input  logic [c_TGT_W-1:0]  in_target,
    input  logic                in_last,
    output logic                im_we,
    output logic [ADDR_W-1:0]   im_addr,
    output logic [31:0]         im_wdata,
    output logic [ADDR_W:0]     count,
    output logic                done,
    output logic                full,
    output logic                err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_accept;
    logic              w_legal;
    logic              w_last_addr;
    logic [31:0]       w_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_err;

    inst_pack u_pack (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (w_word),
        .legal  (w_legal)
    );

    assign in_ready    = (r_state == c_ST_RUN);
    assign w_accept    = in_valid && in_ready;
    // count never exceeds 2^ADDR_W-1 while in RUN, so the low bits suffice
    assign w_last_addr = (r_count[ADDR_W-1:0] == {ADDR_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_accept && (in_last || (w_legal && w_last_addr)))
                           w_state_next = c_ST_DONE;
            c_ST_DONE: if (start) w_state_next = c_ST_RUN;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (start && (r_state != c_ST_RUN)) begin
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= r_count + 1'b1;
                    if (w_last_addr) r_full <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign count    = r_count;
    assign full     = r_full;
    assign err      = r_err;
    assign done     = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_inst_encoder                                           |
// | Brief  : directed self-checking bench for inst_encoder             |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, in_valid, in_last;
    logic [4:0]  in_kind, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_ready, im_we, done, full, err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [10:0] count;

    logic        start2, valid2;
    logic [15:0] imm2;
    logic        ready2, we2, done2, full2, err2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int r_vectors = 0;
    int r_errors  = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(10)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count),
        .done(done), .full(full), .err(err)
    );

    inst_encoder #(.ADDR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(valid2), .in_ready(ready2),
        .in_kind(5'd13), .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0),
        .in_shamt(5'd0), .in_imm(imm2), .in_target(26'd0), .in_last(1'b0),
        .im_we(we2), .im_addr(addr2), .im_wdata(wdata2), .count(count2),
        .done(done2), .full(full2), .err(err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_vectors++;
        assert (obs === exp) else begin
            r_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        start = 0; in_valid = 0; in_last = 0; in_kind = 0; in_rs = 0; in_rt = 0;
        in_rd = 0; in_shamt = 0; in_imm = 0; in_target = 0;
        start2 = 0; valid2 = 0; imm2 = 0;
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_outs", {im_we, im_addr, im_wdata, count, done, full, err}, 0);
        rst = 1'b0;
        tick();

        // add, single-beat program
        pulse_start();
        chk("run_ready", in_ready, 1);
        beat(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("add", {im_we, im_addr, im_wdata, count}, {1'b1, 10'd0, 32'h00221820, 11'd1});

        // lw then sll back-to-back; sll's rs must be dropped
        pulse_start();
        chk("restart_count", count, 0);
        beat(5'd9, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
        tick();
        chk("lw", {im_we, im_addr, im_wdata}, {1'b1, 10'd0, 32'h8FA80004});
        beat(5'd5, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0, 26'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("sll", {im_we, im_addr, im_wdata, count}, {1'b1, 10'd1, 32'h00031100, 11'd2});
        tick();
        chk("hold", {im_we, im_addr, im_wdata, done, in_ready},
            {1'b0, 10'd1, 32'h00031100, 1'b1, 1'b0});

        // jal with last
        pulse_start();
        beat(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("jal", {im_we, im_addr, im_wdata, done, in_ready},
            {1'b1, 10'd0, 32'h0C000100, 1'b1, 1'b0});

        // lui ignores rs; jr, sra, beq exercise field forcing
        pulse_start();
        beat(5'd12, 5'd9, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0);
        tick();
        chk("lui", {im_we, im_addr, im_wdata}, {1'b1, 10'd0, 32'h3C011234});
        beat(5'd8, 5'd31, 5'd6, 5'd7, 5'd3, 16'd0, 26'd0, 1'b0);
        tick();
        chk("jr", {im_addr, im_wdata}, {10'd1, 32'h03E00008});
        beat(5'd7, 5'd5, 5'd4, 5'd5, 5'd31, 16'd0, 26'd0, 1'b0);
        tick();
        chk("sra", {im_addr, im_wdata}, {10'd2, 32'h00042FC3});
        beat(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("beq", {im_addr, im_wdata, count}, {10'd3, 32'h1022FFFF, 11'd4});

        // illegal kind then ori
        pulse_start();
        chk("err_cleared", err, 0);
        beat(5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0);
        tick();
        chk("illegal", {im_we, count, err, in_ready}, {1'b0, 11'd0, 1'b1, 1'b1});
        beat(5'd11, 5'd2, 5'd5, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ori", {im_we, im_addr, im_wdata, count, err}, {1'b1, 10'd0, 32'h344500FF, 11'd1, 1'b1});

        // ADDR_W=2 fill: valid held for five cycles
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imm2 = 16'(i);
            tick();
            chk("fill_wr", {we2, addr2, wdata2}, {1'b1, 2'(i), 32'h20000000 | 32'(i)});
        end
        chk("fill_full", {full2, done2, ready2, count2}, {1'b1, 1'b1, 1'b0, 3'd4});
        imm2 = 16'd4;
        tick();
        valid2 = 1'b0;
        chk("fill_5th", {we2, count2, addr2}, {1'b0, 3'd4, 2'd3});

        // reset the cycle after an accepted beat
        pulse_start();
        beat(5'd13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0007, 26'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid", {in_ready, im_we, im_addr, im_wdata, count, done, full, err}, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_after", {in_ready, im_we, count, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 10, sets the instruction-memory word-address width (1024 words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  pulse; begins a new program load at word 0.
REQ-005 in_valid  input  1  instruction beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_kind  input  5  instruction kind: 0 add, 1 addu, 2 sub, 3 subu, 4 slt, 5 sll, 6 srl, 7 sra, 8 jr, 9 lw, 10 sw, 11 ori, 12 lui, 13 addi, 14 slti, 15 beq, 16 bne, 17 j, 18 jal; 19-31 illegal.
REQ-008 in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
REQ-009 in_imm  input  16  immediate/offset; in_target input 26 jump target.
REQ-010 in_last  input  1  beat is the final instruction of the program.
REQ-011 im_we  output  1  instruction-memory write strobe.
REQ-012 im_addr  output  ADDR_W  word address; im_wdata output 32 encoded MIPS word.
REQ-013 count  output  ADDR_W+1  words written since start.
REQ-014 done  output  1  level, load finished; full output 1, memory filled; err output 1, sticky illegal kind seen.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE --start--> RUN; DONE --start--> RUN; start in RUN is ignored.
REQ-017 Entering RUN clears count, err, full and done.
REQ-018 in_ready = 1 only in RUN; a beat is accepted when in_valid && in_ready.
REQ-019 Accepted legal beat in cycle N: im_we=1 in cycle N+1 with im_addr = count value at N and im_wdata = encoded word; count increments by 1 at the same edge that registers the write.
REQ-020 R-format {000000, rs, rt, rd, shamt, func}; func add 100000, addu 100001, sub 100010, subu 100011, slt 101010, sll 000000, srl 000010, sra 000011, jr 001000.
REQ-021 Shifts force rs=0; jr forces rt=rd=shamt=0; non-shift R kinds force shamt=0.
REQ-022 I-format {op, rs, rt, imm}; op lw 100011, sw 101011, ori 001101, lui 001111 (rs forced 0), addi 001000, slti 001010, beq 000100, bne 000101.
REQ-023 J-format {op, target}; op j 000010, jal 000011.
REQ-024 Illegal kind: beat consumed, no write, count unchanged, err set until next start.
REQ-025 Accepted beat with in_last=1 (legal or illegal) moves FSM to DONE after that beat; done=1 from the following cycle.
REQ-026 Write to address 2^ADDR_W-1 sets full=1 and moves FSM to DONE, regardless of in_last.
REQ-027 im_we is a single-cycle pulse per accepted legal beat; im_addr/im_wdata hold last values when im_we=0.
REQ-028 Throughput one beat per cycle; back-to-back beats produce consecutive addresses.

Reset
REQ-029 rst asserted forces immediately: state IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, count=0, done=0, full=0, err=0.
REQ-030 Reset mid-load discards any pending write; no im_we after rst deasserts until a new start and accepted beat.

Structure
REQ-031 Shared package holds the kind enumeration, all opcode and func constants, and format field widths; the control decoder uses the same package.
REQ-032 One combinational sub-module inst_pack maps (kind, fields) to {word, legal}; inst_encoder holds the FSM, counter and output register.

Verification
REQ-033 start; add rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221820, count=1.
REQ-034 Back-to-back lw rs=29 rt=8 imm=4, sll rt=3 rd=2 shamt=4 rs=7 -> 0x8FA80004 @0, 0x00031100 @1 (rs ignored).
REQ-035 jal target=0x100 with in_last=1 -> 0x0C000100 @0, then done=1, in_ready=0; lui rt=1 imm=0x1234 after new start -> 0x3C011234 @0.
REQ-036 kind=25 then ori -> no write for 25, err=1, ori written @0, count=1.
REQ-037 ADDR_W=2: five continuous beats -> writes at 0..3, full=1, done=1, fifth beat not accepted.
REQ-038 rst asserted the cycle after an accepted beat -> im_we stays 0, all outputs zero, state IDLE.
